mux_rr_sched: RTL and testbench

MUX_RR_SCHED -- requirements
Module: mux_rr_sched

---
 rtl/mux_rr_sched.sv | 143 ++++++++++++++
 tb/tb_mux_rr_sched.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin scheduler in front of an external N_CH:1 data mux.
// It picks a requesting channel, drives the mux selector, captures the returned
// word into a one-entry output register and acknowledges the channel.
// The output register is drained through a valid/ready handshake.
// Optional build macro MUX_RR_SCHED_XFER_CNT_EN adds a 16-bit count of
// completed output transfers on xfer_cnt_o.
module mux_rr_sched #(
    parameter int  W_DATA = 8,
    parameter int  N_CH   = 4,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   req_i,
    output logic [N_CH-1:0]   ack_o,
    output logic [SEL_W-1:0]  select_o,
    input  logic [W_DATA-1:0] sltd_i,
    output logic [W_DATA-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i
`ifdef MUX_RR_SCHED_XFER_CNT_EN
    ,
    output logic [15:0]       xfer_cnt_o
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t              state_r;
    logic [SEL_W-1:0]    last_q;
    logic [N_CH-1:0]     ack_r;
    logic [W_DATA-1:0]   data_r;
    logic                valid_r;

    logic [SEL_W-1:0]    winner_s;
    logic                found_s;
    logic [SEL_W:0]      idx_s;
    logic [SEL_W:0]      sum_s;
    logic                any_req_s;
    logic                capture_s;
    logic                xfer_s;

    // One-hot grant vector for a channel index.
    function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot = {{(N_CH-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Round-robin search: start just after the last grant, wrap, last grant searched last.
    always_comb begin
        winner_s = last_q;
        found_s  = 1'b0;
        idx_s    = '0;
        sum_s    = '0;
        for (int i = 1; i <= N_CH; i++) begin
            sum_s    = {1'b0, last_q} + (SEL_W+1)'(i);
            idx_s    = (sum_s >= (SEL_W+1)'(N_CH)) ? (sum_s - (SEL_W+1)'(N_CH)) : sum_s;
            winner_s = (!found_s && req_i[idx_s[SEL_W-1:0]]) ? idx_s[SEL_W-1:0] : winner_s;
            found_s  = found_s | req_i[idx_s[SEL_W-1:0]];
        end
    end

    assign any_req_s = |req_i;
    // A new word is taken when the output register is empty or being drained now.
    assign capture_s = any_req_s && ((state_r == ST_IDLE) || ready_i);
    assign xfer_s    = (state_r == ST_HOLD) && ready_i;

    // Selector follows the winner while anyone requests, otherwise parks on the last grant.
    assign select_o = any_req_s ? winner_s : last_q;

    // Scheduler FSM with registered grant, data and valid outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            last_q  <= SEL_W'(N_CH-1);
            ack_r   <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (capture_s) begin
                        data_r  <= sltd_i;
                        last_q  <= winner_s;
                        ack_r   <= onehot(winner_s);
                        valid_r <= 1'b1;
                        state_r <= ST_HOLD;
                    end else begin
                        ack_r   <= '0;
                        valid_r <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (capture_s) begin
                        data_r  <= sltd_i;
                        last_q  <= winner_s;
                        ack_r   <= onehot(winner_s);
                        valid_r <= 1'b1;
                        state_r <= ST_HOLD;
                    end else if (xfer_s) begin
                        ack_r   <= '0;
                        valid_r <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        ack_r   <= '0;
                        valid_r <= 1'b1;
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    ack_r   <= '0;
                    valid_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack_o   = ack_r;
    assign data_o  = data_r;
    assign valid_o = valid_r;

`ifdef MUX_RR_SCHED_XFER_CNT_EN
    logic [15:0] xfer_cnt_r;

    // Count completed output transfers; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xfer_cnt_r <= 16'h0000;
        end else if (xfer_s) begin
            xfer_cnt_r <= xfer_cnt_r + 16'h0001;
        end else begin
            xfer_cnt_r <= xfer_cnt_r;
        end
    end

    assign xfer_cnt_o = xfer_cnt_r;
`endif

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed bench for mux_rr_sched (default 4 channels x 8 bits).
// Channel k presents word 0xA0+k through a behavioural mux driven by select_o.
module tb_mux_rr_sched;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] ack;
    logic [1:0] select;
    logic [7:0] sltd;
    logic [7:0] data;
    logic       valid;
    logic       ready;
`ifdef MUX_RR_SCHED_XFER_CNT_EN
    logic [15:0] xfer_cnt;
`endif

    logic [7:0] ch_data [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] req;
        logic       ready;
        logic [1:0] exp_sel;
        logic [3:0] exp_ack;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vec [19];

    mux_rr_sched #(.W_DATA(8), .N_CH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req),
        .ack_o    (ack),
        .select_o (select),
        .sltd_i   (sltd),
        .data_o   (data),
        .valid_o  (valid),
        .ready_i  (ready)
`ifdef MUX_RR_SCHED_XFER_CNT_EN
        ,
        .xfer_cnt_o (xfer_cnt)
`endif
    );

    assign sltd = ch_data[select];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) ch_data[k] = 8'hA0 + 8'(k);

        //          req      rdy   sel   ack      v     data
        vec[0]  = '{4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 8'hA0};
        vec[1]  = '{4'b1111, 1'b1, 2'd1, 4'b0010, 1'b1, 8'hA1};
        vec[2]  = '{4'b1111, 1'b1, 2'd2, 4'b0100, 1'b1, 8'hA2};
        vec[3]  = '{4'b1111, 1'b1, 2'd3, 4'b1000, 1'b1, 8'hA3};
        vec[4]  = '{4'b1111, 1'b1, 2'd0, 4'b0001, 1'b1, 8'hA0};
        vec[5]  = '{4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0, 8'hA0};
        vec[6]  = '{4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0, 8'hA0};
        vec[7]  = '{4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 8'hA2};
        vec[8]  = '{4'b0100, 1'b0, 2'd2, 4'b0000, 1'b1, 8'hA2};
        vec[9]  = '{4'b0100, 1'b0, 2'd2, 4'b0000, 1'b1, 8'hA2};
        vec[10] = '{4'b0100, 1'b0, 2'd2, 4'b0000, 1'b1, 8'hA2};
        vec[11] = '{4'b1011, 1'b0, 2'd3, 4'b0000, 1'b1, 8'hA2};
        vec[12] = '{4'b0000, 1'b1, 2'd2, 4'b0000, 1'b0, 8'hA2};
        vec[13] = '{4'b1000, 1'b0, 2'd3, 4'b1000, 1'b1, 8'hA3};
        vec[14] = '{4'b1010, 1'b1, 2'd1, 4'b0010, 1'b1, 8'hA1};
        vec[15] = '{4'b1010, 1'b1, 2'd3, 4'b1000, 1'b1, 8'hA3};
        vec[16] = '{4'b1010, 1'b1, 2'd1, 4'b0010, 1'b1, 8'hA1};
        vec[17] = '{4'b0000, 1'b0, 2'd1, 4'b0000, 1'b1, 8'hA1};
        vec[18] = '{4'b0000, 1'b1, 2'd1, 4'b0000, 1'b0, 8'hA1};

        // Reset held with all channels requesting.
        rst   = 1'b0;
        req   = 4'b1111;
        ready = 1'b0;
        #12;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_sel", 32'(select), 32'd0);
        #5 rst = 1'b1;   // release between edges

        // Table-driven sequence: round robin, backpressure, idle ready, wrap/skip.
        for (int i = 0; i < 19; i++) begin
            req   = vec[i].req;
            ready = vec[i].ready;
            #1;
            check($sformatf("v%0d_sel", i), 32'(select), 32'(vec[i].exp_sel));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ack", i), 32'(ack), 32'(vec[i].exp_ack));
            check($sformatf("v%0d_valid", i), 32'(valid), 32'(vec[i].exp_valid));
            check($sformatf("v%0d_data", i), 32'(data), 32'(vec[i].exp_data));
        end

        // Reset between edges while holding a word.
        req   = 4'b0100;
        ready = 1'b0;
        @(posedge clk);
        #1;
        check("mid_pre_valid", 32'(valid), 32'd1);
        check("mid_pre_data", 32'(data), 32'hA2);
        #2;
        rst = 1'b0;
        req = 4'b0000;
        #1;
        check("mid_valid", 32'(valid), 32'd0);
        check("mid_ack", 32'(ack), 32'd0);
        check("mid_data", 32'(data), 32'd0);
        check("mid_last", 32'(select), 32'd3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rel_ack", 32'(ack), 32'd0);
        check("rel_valid", 32'(valid), 32'd0);
        req = 4'b0001;
        #1;
        check("rel_sel", 32'(select), 32'd0);
        @(posedge clk);
        #1;
        check("rel_grant", 32'(ack), 32'b0001);
        check("rel_gdata", 32'(data), 32'hA0);

`ifdef MUX_RR_SCHED_XFER_CNT_EN
        // Transfer counter: 65535 transfers, stall, then wrap.
        #2 rst = 1'b0;
        req   = 4'b1111;
        ready = 1'b1;
        #1;
        check("cnt_rst", 32'(xfer_cnt), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("cnt_first", 32'(xfer_cnt), 32'd0);
        repeat (65535) @(posedge clk);
        #1;
        check("cnt_full", 32'(xfer_cnt), 32'hFFFF);
        ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("cnt_stall", 32'(xfer_cnt), 32'hFFFF);
        ready = 1'b1;
        @(posedge clk);
        #1;
        check("cnt_wrap", 32'(xfer_cnt), 32'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
